// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share one memory port.
// Round-robin on ties, registered memory request, and a wait-state timeout that aborts with an error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  // state   | meaning
  // IDLE    | no transaction outstanding, arbitrate eligible requests
  // BUSY_IF | fetch on the memory port, waiting for mem_ready or timeout
  // BUSY_LS | load/store on the memory port, waiting for mem_ready or timeout
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic       GRANT_IF  = 1'b0;
  localparam logic       GRANT_LS  = 1'b1;

  state_t     state;
  logic       last_grant;
  logic [7:0] wait_cnt;
  logic       if_elig;
  logic       ls_elig;
  logic       pick_ls;

  // A requester being acked this cycle is still holding req and must not win again.
  assign if_elig = if_req & ~if_ack;
  assign ls_elig = ls_req & ~ls_ack;
  assign pick_ls = ls_elig & (~if_elig | (last_grant == GRANT_IF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      ls_ack     <= 1'b0;
      ls_err     <= 1'b0;
      ls_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ls) begin
            mem_req    <= 1'b1;
            mem_we     <= ls_we;
            mem_addr   <= ls_addr;
            mem_wdata  <= ls_wdata;
            mem_be     <= ls_be;
            wait_cnt   <= '0;
            last_grant <= GRANT_LS;
            state      <= BUSY_LS;
          end else if (if_elig) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            wait_cnt   <= '0;
            last_grant <= GRANT_IF;
            state      <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_err   <= 1'b0;
            if_rdata <= mem_rdata;
            state    <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_err   <= 1'b1;
            if_rdata <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BUSY_LS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            ls_ack  <= 1'b1;
            ls_err  <= 1'b0;
            if (!mem_we) ls_rdata <= mem_rdata;
            state   <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_req  <= 1'b0;
            ls_ack   <= 1'b1;
            ls_err   <= 1'b1;
            ls_rdata <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, round-robin ties, wait states, timeout, reset, held request.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_ls_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_wdata = 0; ls_be = 0; mem_rdata = 0; mem_ready = 0;
    tick(); tick();
    vectors++;
    if ({mem_req, mem_we, if_ack, ls_ack, if_err, ls_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_ack, ls_ack, if_err, ls_err});
    end
    vectors++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h be=%h if_rdata=%h ls_rdata=%h want all 0",
               mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h0000_0010;
    tick();
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
      miscompares++;
      $display("FAIL fetch_grant: req=%b we=%b addr=%h be=%h want 1 0 00000010 f", mem_req, mem_we, mem_addr, mem_be);
    end
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    tick();
    vectors++;
    if ({if_ack, if_err, if_rdata, mem_req, ls_ack} !== {1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fetch_ack: ack=%b err=%b rdata=%h mem_req=%b ls_ack=%b want 1 0 00500093 0 0",
               if_ack, if_err, if_rdata, mem_req, ls_ack);
    end
    if_req = 0; mem_ready = 0;
    tick();
    vectors++;
    if (if_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse: if_ack=%b want 0", if_ack);
    end
  endtask

  task automatic test_tie();
    if_req = 1; if_addr = 32'h40; ls_req = 1; ls_we = 0; ls_addr = 32'h100;
    tick();
    vectors++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL tie1_ls_first: req=%b we=%b addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    tick();
    exp_ls_rdata = 32'hA5A5_0001;
    vectors++;
    if ({ls_ack, ls_err, ls_rdata, if_ack} !== {1'b1, 1'b0, exp_ls_rdata, 1'b0}) begin
      miscompares++;
      $display("FAIL tie1_ls_ack: ack=%b err=%b rdata=%h if_ack=%b want 1 0 %h 0", ls_ack, ls_err, ls_rdata, if_ack, exp_ls_rdata);
    end
    mem_ready = 0;
    tick();
    ls_req = 0;
    vectors++;
    if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h40, 4'hF}) begin
      miscompares++;
      $display("FAIL tie1_if_second: req=%b addr=%h be=%h want 1 00000040 f", mem_req, mem_addr, mem_be);
    end
    mem_ready = 1; mem_rdata = 32'h0000_0BB0;
    tick();
    vectors++;
    if ({if_ack, if_rdata, ls_ack} !== {1'b1, 32'h0BB0, 1'b0}) begin
      miscompares++;
      $display("FAIL tie1_if_ack: if_ack=%b rdata=%h ls_ack=%b want 1 00000bb0 0", if_ack, if_rdata, ls_ack);
    end
    if_req = 0; mem_ready = 0;
    tick();
    // lone LS grant moves last_grant to LS, so the next tie belongs to IF
    ls_req = 1; ls_addr = 32'h104;
    tick();
    mem_ready = 1; mem_rdata = 32'h1111_0000;
    tick();
    exp_ls_rdata = 32'h1111_0000;
    ls_req = 0; mem_ready = 0;
    tick();
    if_req = 1; if_addr = 32'h44; ls_req = 1; ls_addr = 32'h108;
    tick();
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      miscompares++;
      $display("FAIL tie2_if_first: req=%b addr=%h want 1 00000044", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h2222_0000;
    tick();
    mem_ready = 0;
    tick();
    if_req = 0;
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h108}) begin
      miscompares++;
      $display("FAIL tie2_ls_second: req=%b addr=%h want 1 00000108", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h3333_0000;
    tick();
    exp_ls_rdata = 32'h3333_0000;
    vectors++;
    if ({ls_ack, ls_rdata} !== {1'b1, exp_ls_rdata}) begin
      miscompares++;
      $display("FAIL tie2_ls_ack: ack=%b rdata=%h want 1 %h", ls_ack, ls_rdata, exp_ls_rdata);
    end
    ls_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_store_wait();
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
    mem_rdata = 32'h9999_9999;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ls_ack} !==
          {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
        miscompares++;
        $display("FAIL store_stable[%0d]: req=%b we=%b addr=%h wdata=%h be=%b ack=%b", i,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_be, ls_ack);
      end
      if (i == 3) mem_ready = 1;
      tick();
    end
    vectors++;
    if ({ls_ack, ls_err, ls_rdata, mem_req} !== {1'b1, 1'b0, exp_ls_rdata, 1'b0}) begin
      miscompares++;
      $display("FAIL store_ack: ack=%b err=%b rdata=%h mem_req=%b want 1 0 %h 0", ls_ack, ls_err, ls_rdata, mem_req, exp_ls_rdata);
    end
    ls_req = 0; ls_we = 0; mem_ready = 0;
    tick();
    vectors++;
    if (ls_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL store_single_ack: ls_ack=%b want 0", ls_ack);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    ls_req = 1; ls_we = 0; ls_addr = 32'h300; mem_ready = 0;
    tick();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != 16) begin
      miscompares++;
      $display("FAIL timeout_len: mem_req high %0d cycles want 16", cnt);
    end
    vectors++;
    if ({ls_ack, ls_err, ls_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_abort: ack=%b err=%b rdata=%h want 1 1 00000000", ls_ack, ls_err, ls_rdata);
    end
    ls_req = 0;
    tick();
    ls_req = 1; ls_addr = 32'h304;
    tick();
    repeat (15) tick();
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_cycle16_req: mem_req=%b want 1", mem_req);
    end
    mem_ready = 1; mem_rdata = 32'h0000_1234;
    tick();
    vectors++;
    if ({ls_ack, ls_err, ls_rdata} !== {1'b1, 1'b0, 32'h1234}) begin
      miscompares++;
      $display("FAIL timeout_ready_wins: ack=%b err=%b rdata=%h want 1 0 00001234", ls_ack, ls_err, ls_rdata);
    end
    ls_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    if_req = 1; if_addr = 32'h60;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_req, if_ack, ls_ack, mem_addr, mem_be, if_rdata, ls_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: req=%b if_ack=%b ls_ack=%b addr=%h be=%h if_rdata=%h ls_rdata=%h",
               mem_req, if_ack, ls_ack, mem_addr, mem_be, if_rdata, ls_rdata);
    end
    if_req = 0; mem_ready = 1;
    tick();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_ack === 1'b1 || mem_req === 1'b1) acks++;
    end
    mem_ready = 0;
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_ack: %0d cycles with ack or req want 0", acks);
    end
    if_req = 1; if_addr = 32'h80;
    tick();
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      miscompares++;
      $display("FAIL reset_mid_regrant: req=%b addr=%h want 1 00000080", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h0808_0808;
    tick();
    vectors++;
    if ({if_ack, if_err, if_rdata} !== {1'b1, 1'b0, 32'h0808_0808}) begin
      miscompares++;
      $display("FAIL reset_mid_ack: ack=%b err=%b rdata=%h want 1 0 08080808", if_ack, if_err, if_rdata);
    end
    if_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_held_req();
    if_req = 1; if_addr = 32'h20;
    tick();
    mem_ready = 1; mem_rdata = 32'h0000_0020;
    tick();
    mem_ready = 0;
    vectors++;
    if (if_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL held_ack: if_ack=%b want 1", if_ack);
    end
    tick();
    vectors++;
    if ({mem_req, if_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL held_no_regrant: mem_req=%b if_ack=%b want 0 0", mem_req, if_ack);
    end
    if_req = 0;
    tick();
  endtask

  initial begin
    exp_ls_rdata = '0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_store_wait();
    test_timeout();
    test_reset_mid();
    test_held_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles waiting for mem_ready before abort; legal range 2..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 if_req  input  1  instruction-fetch read request.
REQ-008 if_addr  input  ADDR_W  fetch address.
REQ-009 if_ack  output  1  one-cycle fetch-completion pulse.
REQ-010 if_rdata  output  DATA_W  fetched word, valid when if_ack=1.
REQ-011 if_err  output  1  fetch aborted by timeout, valid when if_ack=1.
REQ-012 ls_req  input  1  load/store request.
REQ-013 ls_we  input  1  1=store, 0=load.
REQ-014 ls_addr  input  ADDR_W  load/store address.
REQ-015 ls_wdata  input  DATA_W  store data.
REQ-016 ls_be  input  DATA_W/8  store byte enables.
REQ-017 ls_ack  output  1  one-cycle load/store-completion pulse.
REQ-018 ls_rdata  output  DATA_W  load data, valid when ls_ack=1 and ls_we was 0.
REQ-019 ls_err  output  1  load/store aborted by timeout, valid when ls_ack=1.
REQ-020 mem_req, mem_we, mem_addr, mem_wdata, mem_be  output  1/1/ADDR_W/DATA_W/DATA_W/8  shared memory request, all registered.
REQ-021 mem_rdata  input  DATA_W  memory read data, sampled when mem_ready=1.
REQ-022 mem_ready  input  1  memory completion, sampled only while mem_req=1.

Function
REQ-023 Requesters SHALL hold req and all request fields stable until their ack; they may drop req on the cycle after ack.
REQ-024 FSM states SHALL be IDLE, BUSY_IF, BUSY_LS; each transaction SHALL be completed by exactly one ack pulse.
REQ-025 In IDLE, a requester whose ack is high in that cycle SHALL be ignored for arbitration.
REQ-026 In IDLE with one eligible request, the arbiter SHALL grant it at the next edge.
REQ-027 In IDLE with both eligible, the arbiter SHALL grant the requester not granted last (round-robin); last_grant resets to IF, so the first tie goes to LS.
REQ-028 On grant, mem_addr/mem_we/mem_wdata/mem_be SHALL be loaded from the winner (IF forces mem_we=0, mem_be all ones), mem_req set to 1, and last_grant updated.
REQ-029 In BUSY_x, mem_req and all mem_* fields SHALL stay constant until mem_ready=1 or timeout.
REQ-030 On a BUSY-cycle edge with mem_ready=1: mem_req cleared, x_ack pulsed for one cycle, x_err=0, x_rdata loaded from mem_rdata for reads (ls_rdata unchanged on stores), state returns to IDLE.
REQ-031 Zero-wait-state latency SHALL be: request high in cycle N -> mem_req high in N+1 -> ack high in N+2.
REQ-032 A wait counter SHALL clear on grant and increment each BUSY cycle without mem_ready; when it reaches TIMEOUT-1 without mem_ready, the transaction SHALL abort: mem_req cleared, x_ack=1, x_err=1, x_rdata=0, state IDLE.
REQ-033 mem_ready on the timeout cycle SHALL take precedence: normal completion, no error.
REQ-034 mem_ready while mem_req=0 SHALL be ignored.
REQ-035 if_ack and ls_ack SHALL never be high in the same cycle; a new grant SHALL not be issued in the same cycle as an ack.

Reset
REQ-036 While rst=0: state IDLE; mem_req, mem_we, if_ack, ls_ack, if_err, ls_err = 0; mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata = 0; counter 0; last_grant IF.
REQ-037 Reset during BUSY SHALL abandon the transaction with no ack; after release the first request is granted per REQ-026/027.

Verification
REQ-038 Single fetch: if_req=1, if_addr=0x0000_0010, mem_ready=1 in first BUSY cycle with mem_rdata=0x0050_0093 -> if_ack=1 two cycles after request, if_rdata=0x0050_0093, if_err=0.
REQ-039 Tie after reset: if_req and ls_req (load, ls_addr=0x100) raised together -> LS served first, then IF; second tie served to the other requester, alternating.
REQ-040 Store with wait states: ls_we=1, ls_addr=0x200, ls_wdata=0xDEAD_BEEF, ls_be=4'b0011, mem_ready after 3 BUSY cycles -> mem_* stable for 4 cycles, single ls_ack, ls_err=0, ls_rdata unchanged.
REQ-041 Timeout: TIMEOUT=16, mem_ready held 0 -> mem_req high exactly 16 cycles, then ls_ack=1, ls_err=1, ls_rdata=0; with mem_ready=1 on the 16th cycle -> normal completion.
REQ-042 Reset mid-transaction: rst=0 in second BUSY cycle -> all outputs 0 immediately, no ack after release; a new if_req is then served normally.
REQ-043 Held request: requester keeps req high one cycle after ack -> no duplicate grant in the ack cycle.
